// File: rtl/ca_pkg.sv
// Shared definitions for the 1-D cellular-automaton line renderer: geometry defaults,
// FSM states, LFSR feedback mask and cell/colour levels.
package ca_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        StIdle,
        StSeed,
        StArm,
        StRun
    } state_e;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback is bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam logic LIVE = 1'b1;
    localparam logic DEAD = 1'b0;

endpackage

// File: rtl/ca_rule_step.sv
// One generation of an elementary cellular automaton over a ring of W cells.
module ca_rule_step #(
    parameter int unsigned W = 640
) (
    input  logic [W-1:0] row_in,
    input  logic [7:0]   rule,
    output logic [W-1:0] row_out
);

    logic [W-1:0] left_nb;
    logic [W-1:0] right_nb;

    // left_nb[i] = row_in[i-1], right_nb[i] = row_in[i+1], both wrapping around the ring
    assign left_nb  = {row_in[W-2:0], row_in[W-1]};
    assign right_nb = {row_in[0], row_in[W-1:1]};

    always_comb begin
        row_out = '0;
        for (int i = 0; i < W; i++) begin
            row_out[i] = rule[{left_nb[i], row_in[i], right_nb[i]}];
        end
    end

endmodule

// File: rtl/ca_line_renderer.sv
// Pixel source for the VGA controller: holds one CA generation and steps it on every
// new visible scan line, restarting from the seed row at the top of each frame.
module ca_line_renderer
    import ca_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned COLOR_W   = 10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic [COORD_W-1:0] iCoord_X,
    input  logic [COORD_W-1:0] iCoord_Y,
    input  logic [7:0]         iRule,
    input  logic               iSeed_sel,
    input  logic               iStart,
    input  logic               iFreeze,
    output logic [COLOR_W-1:0] oRed,
    output logic [COLOR_W-1:0] oGreen,
    output logic [COLOR_W-1:0] oBlue,
    output logic               oBusy,
    output logic               oFrame_done
);

    localparam int unsigned CNT_W = $clog2(H_ACTIVE);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_ACTIVE - 1);

    state_e              state_q, state_d;
    logic [H_ACTIVE-1:0] row_q, row_d;
    logic [H_ACTIVE-1:0] seed_row_q, seed_row_d;
    logic [H_ACTIVE-1:0] row_next;
    logic [7:0]          rule_q, rule_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [COORD_W-1:0]  y_q;
    logic                seed_sel_q, seed_sel_d;
    logic                pix_q, pix_d;
    logic                done_q, done_d;
    logic                line_evt;
    logic                frame_start;

    ca_rule_step #(
        .W (H_ACTIVE)
    ) u_rule_step (
        .row_in  (row_q),
        .rule    (rule_q),
        .row_out (row_next)
    );

    // Blanking lines hold Y out of range, so only visible line changes count
    assign line_evt    = (iCoord_Y != y_q) && (iCoord_Y <= Y_LAST);
    assign frame_start = line_evt && (iCoord_Y == '0);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        seed_row_d = seed_row_q;
        rule_d     = rule_q;
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        seed_sel_d = seed_sel_q;
        pix_d      = DEAD;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (iStart) begin
                    state_d    = StSeed;
                    seed_sel_d = iSeed_sel;
                    cnt_d      = '0;
                end
            end
            StSeed: begin
                if (!seed_sel_q) begin
                    row_d               = '0;
                    row_d[H_ACTIVE / 2] = LIVE;
                    state_d             = StArm;
                end else begin
                    row_d  = {row_q[H_ACTIVE-2:0], lfsr_q[0]};
                    lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = StArm;
                    end
                end
            end
            StArm: begin
                // row_q already holds the fresh seed, so it is kept rather than reloaded
                seed_row_d = row_q;
                if (frame_start) begin
                    rule_d  = iRule;
                    state_d = StRun;
                end
            end
            StRun: begin
                pix_d = (iCoord_X <= X_LAST) ? row_q[iCoord_X] : DEAD;
                if (iStart) begin
                    state_d    = StSeed;
                    seed_sel_d = iSeed_sel;
                    cnt_d      = '0;
                end else if (frame_start) begin
                    row_d  = seed_row_q;
                    rule_d = iRule;
                end else begin
                    if (line_evt && !iFreeze) begin
                        row_d = row_next;
                    end
                    done_d = line_evt && (iCoord_Y == Y_LAST);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= StIdle;
            row_q      <= '0;
            seed_row_q <= '0;
            rule_q     <= '0;
            lfsr_q     <= LFSR_SEED;
            cnt_q      <= '0;
            y_q        <= '1;
            seed_sel_q <= 1'b0;
            pix_q      <= DEAD;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            seed_row_q <= seed_row_d;
            rule_q     <= rule_d;
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            y_q        <= iCoord_Y;
            seed_sel_q <= seed_sel_d;
            pix_q      <= pix_d;
            done_q     <= done_d;
        end
    end

    assign oRed        = pix_q ? {COLOR_W{LIVE}} : {COLOR_W{DEAD}};
    assign oGreen      = pix_q ? {COLOR_W{LIVE}} : {COLOR_W{DEAD}};
    assign oBlue       = pix_q ? {COLOR_W{LIVE}} : {COLOR_W{DEAD}};
    assign oBusy       = (state_q == StSeed);
    assign oFrame_done = done_q;

endmodule

// File: tb/tb_ca_line_renderer.sv
// Scoreboard bench for ca_line_renderer: a behavioural CA/LFSR model queues the expected
// pixel and frame-done for each request and the queue is drained one clock later.
module tb_ca_line_renderer;

    localparam int H = 640;
    localparam int V = 480;

    typedef struct {
        logic pix;
        logic done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  cx, cy;
    logic [7:0]  rule;
    logic        seed_sel, start, freeze;
    logic [9:0]  red, green, blue;
    logic        busy, frame_done;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    logic [H-1:0] m_row, m_seed;
    logic [7:0]   m_rule;
    logic [15:0]  m_lfsr;
    logic [9:0]   m_y;
    bit           m_run, m_arm;
    exp_t         sb[$];

    ca_line_renderer dut (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .iCoord_X    (cx),
        .iCoord_Y    (cy),
        .iRule       (rule),
        .iSeed_sel   (seed_sel),
        .iStart      (start),
        .iFreeze     (freeze),
        .oRed        (red),
        .oGreen      (green),
        .oBlue       (blue),
        .oBusy       (busy),
        .oFrame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [H-1:0] ref_step(input logic [H-1:0] r, input logic [7:0] rl);
        logic [H-1:0] nxt;
        logic [2:0]   idx;
        for (int i = 0; i < H; i++) begin
            idx    = {r[(i + H - 1) % H], r[i], r[(i + 1) % H]};
            nxt[i] = rl[idx];
        end
        return nxt;
    endfunction

    // Taps 16,14,13,11 of the polynomial land on bits 0,2,3,5 of a right-shifting register
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    task automatic model_reset();
        m_row  = '0;
        m_seed = '0;
        m_rule = '0;
        m_lfsr = 16'hACE1;
        m_y    = '1;
        m_run  = 0;
        m_arm  = 0;
        sb.delete();
    endtask

    task automatic pixel(input int x, input int y);
        exp_t e;
        bit   evt;
        cx     = 10'(x);
        cy     = 10'(y);
        evt    = (y != int'(m_y)) && (y < V);
        e.pix  = m_run && ((x < H) ? m_row[x] : 1'b0);
        e.done = m_run && evt && (y == V - 1);
        if (evt && y == 0 && (m_run || m_arm)) begin
            m_row  = m_seed;
            m_rule = rule;
            m_run  = 1;
            m_arm  = 0;
        end else if (evt && m_run && !freeze) begin
            m_row = ref_step(m_row, m_rule);
        end
        m_y = 10'(y);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("pixel", {red, green, blue}, e.pix ? 32'h3fff_ffff : 32'h0);
        check_eq("frame_done", frame_done, e.done);
        if (frame_done) done_cnt++;
    endtask

    task automatic start_seed(input bit sel);
        int   busy_cycles;
        logic b;
        cx       = 10'd700;
        cy       = 10'd500;
        seed_sel = sel;
        start    = 1;
        @(posedge clk);
        #1;
        start = 0;
        m_y   = 10'd500;
        m_seed = '0;
        if (!sel) begin
            m_seed[H / 2] = 1'b1;
        end else begin
            // First generated bit ends up in the top cell after H shifts
            for (int k = 0; k < H; k++) begin
                b                = m_lfsr[0];
                m_seed[H - 1 - k] = b;
                m_lfsr           = lfsr_next(m_lfsr);
            end
        end
        m_row = m_seed;
        m_run = 0;
        m_arm = 1;
        busy_cycles = 0;
        while (busy && busy_cycles < 2000) begin
            busy_cycles++;
            @(posedge clk);
            #1;
        end
        check_eq("busy_cycles", busy_cycles, sel ? H : 1);
        check_eq("arm_black", {red, green, blue}, 32'h0);
    endtask

    task automatic run_line(input int y);
        int s[10];
        if (y < 3 || y == 320 || y == 321 || y == V - 1) begin
            for (int x = 0; x < H; x++) pixel(x, y);
        end else begin
            s = '{0, 1, 319, 320, 321, 639, 700, (320 + y) % H, (320 - y + H) % H,
                  int'($urandom_range(0, H - 1))};
            for (int i = 0; i < 10; i++) pixel(s[i], y);
        end
    endtask

    task automatic run_frame(input logic [7:0] fr_rule, input bit frz);
        rule     = fr_rule;
        freeze   = frz;
        done_cnt = 0;
        for (int y = 0; y < V; y++) begin
            // A mid-frame rule change must not alter the running frame
            if (y == 240) rule = ~fr_rule;
            run_line(y);
        end
        pixel(700, 500);
        pixel(700, 500);
        check_eq("done_per_frame", done_cnt, 1);
    endtask

    initial begin
        rst_n    = 0;
        cx       = '0;
        cy       = '0;
        rule     = '0;
        seed_sel = 0;
        start    = 0;
        freeze   = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_colour", {red, green, blue}, 32'h0);
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_done", frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1;

        // Idle: coordinate activity alone never lights a pixel
        for (int y = 0; y < 4; y++) begin
            pixel(320, y);
            pixel(0, y);
        end

        start_seed(0);
        run_frame(8'd90, 0);
        run_frame(8'd0, 0);
        start_seed(1);
        run_frame(8'd30, 0);
        run_frame(8'd110, 1);

        // Reset in the middle of a rule-90 frame
        start_seed(0);
        rule   = 8'd90;
        freeze = 0;
        for (int y = 0; y <= 200; y++) run_line(y);
        for (int x = 0; x < H; x++) begin
            if (m_row[x]) begin
                pixel(x, 200);
                break;
            end
        end
        #2;
        rst_n = 0;
        #1;
        check_eq("async_reset_colour", {red, green, blue}, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int y = 0; y < 6; y++) begin
            pixel(320, y);
            pixel(321, y);
            check_eq("post_reset_busy", busy, 1'b0);
        end
        start_seed(0);
        run_frame(8'd90, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
